// File: rtl/mem_burst_master_pkg.sv
// Shared types for the memory burst master.
// State encoding and read-buffer sizing.
package mem_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/mem_burst_master_if.sv
// Client command/data streams plus the memory port
// driven by mem_burst_master.
interface mem_burst_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  done;
  logic                  busy;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_out;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output done, busy,
    output mem_we, mem_addr, mem_data,
    input  mem_out
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  done, busy,
    input  mem_we, mem_addr, mem_data,
    output mem_out
  );

endinterface

// File: rtl/mem_burst_master_fifo.sv
// Two-entry skid buffer absorbing the memory's
// one-cycle read latency under backpressure.
module rd_skid_fifo
  import mem_master_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CNT_W-1){1'b0}}, push}
                     - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator: streams write words into, or read
// words out of, consecutive addresses of a sync memory.
module mem_burst_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic clk,
  input logic rst,
  mem_burst_master_if.master bus
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  pending;
  logic                  pop;
  logic                  issue;
  logic                  wr_accept;
  logic                  last_word;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occupancy;

  // words buffered plus in flight, after this cycle's pop
  assign pop       = bus.rd_valid & bus.rd_ready;
  assign occupancy = {1'b0, fifo_count}
                   + {{CNT_W{1'b0}}, pending}
                   - {{CNT_W{1'b0}}, pop};
  assign last_word = (remaining == LEN_WIDTH'(1));
  assign wr_accept = (state == WRITE) & bus.wr_valid;
  assign issue     = (state == READ)
                   & (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0)  next_state = DONE;
          else if (bus.cmd_write) next_state = WRITE;
          else                    next_state = READ;
        end
      end
      WRITE: if (wr_accept && last_word) next_state = DONE;
      READ:  if (issue && last_word)     next_state = DRAIN;
      DRAIN: if (!pending && occupancy == '0) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pending   <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= issue;
      if (state == IDLE && bus.cmd_valid) begin
        cur_addr  <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (wr_accept || issue) begin
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.mem_we    = wr_accept & ~rst;
  assign bus.mem_addr  = cur_addr;
  assign bus.mem_data  = bus.wr_data;
  assign bus.rd_valid  = (fifo_count != '0);

  rd_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_fifo (
    .clk      (clk),
    .clr      (rst),
    .push     (pending),
    .push_data(bus.mem_out),
    .pop      (pop),
    .head     (bus.rd_data),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_mem_burst_master.sv
// Randomised and directed bench for mem_burst_master
// against a burst-level reference model.
module tb_mem_burst_master;

  localparam int AW     = 6;
  localparam int DW     = 16;
  localparam int LW     = 7;
  localparam int NWORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_master_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) bus ();

  mem_burst_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // memory instance: registered out, refreshed on non-write cycles
  logic [DW-1:0] mem [NWORDS];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
    else            bus.mem_out <= mem[bus.mem_addr];
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // stimulus controls (main process only)
  logic [DW-1:0] plan_q[$];
  logic [DW-1:0] nodata[$];
  int feed_gen  = 0;
  int gap_fixed = 0;
  bit gap_rand  = 0;
  int rr_mode   = 0;

  // reference model state (compare process only)
  bit            active = 0;
  int            kind = 0;
  int            base, blen, written, popped, wr_left, rd_left;
  longint        acc_cyc = 0, done_due = -1, done_cyc = 0;
  longint        first_pop_cyc = 0, last_pop_cyc = 0;
  int            done_cnt = 0;
  bit            prev_rst = 0;
  logic [DW-1:0] ref_mem [NWORDS];
  logic [DW-1:0] exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  int            wr_log[$];
  logic [DW-1:0] rd_log[$];

  // write-data feeder
  initial begin
    int idx, gap, gen;
    bit hs;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    idx = 0; gap = 0; gen = 0;
    forever begin
      @(negedge clk);
      hs = bus.wr_valid && bus.wr_ready && !rst;
      @(posedge clk); #1;
      if (gen != feed_gen) begin
        gen = feed_gen; idx = 0; gap = 0;
      end else if (hs) begin
        idx++;
        gap = gap_rand ? int'($urandom_range(0, 2)) : gap_fixed;
      end
      if (gap > 0) begin
        bus.wr_valid = 1'b0;
        gap--;
      end else if (idx < plan_q.size()) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = plan_q[idx];
      end else begin
        bus.wr_valid = 1'b0;
      end
    end
  end

  // read-side backpressure
  initial begin
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: bus.rd_ready = 1'b1;
        1: bus.rd_ready = 1'($urandom_range(0, 1));
        2: bus.rd_ready = ~bus.rd_ready;
        default: bus.rd_ready = 1'b0;
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin : cmp
    logic exp_wrr;
    int   issued, wa;
    if (rst) begin
      chk("mem_we_in_reset", 32'(bus.mem_we), 0);
      active = 0; done_due = -1;
      exp_wr.delete(); exp_rd.delete();
      prev_rst = 1;
    end else begin
      if (prev_rst) begin
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        prev_rst = 0;
      end
      exp_wrr = active && kind == 1 && wr_left > 0;
      chk("busy", 32'(bus.busy), 32'(active));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!active));
      chk("wr_ready", 32'(bus.wr_ready), 32'(exp_wrr));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_wrr && bus.wr_valid));
      chk("done", 32'(bus.done), 32'(active && cyc == done_due));
      if (!(active && kind == 2))
        chk("rd_valid_idle", 32'(bus.rd_valid), 0);
      if (exp_wrr && bus.wr_valid) begin
        wa = (base + written) % NWORDS;
        chk("wr_addr", 32'(bus.mem_addr), 32'(wa));
        chk("wr_data", 32'(bus.mem_data), 32'(exp_wr[0]));
        ref_mem[wa] = exp_wr[0];
        wr_log.push_back(int'(bus.mem_addr));
        void'(exp_wr.pop_front());
        written++; wr_left--;
        if (wr_left == 0) done_due = cyc + 1;
      end
      if (active && kind == 2) begin
        issued = (int'(bus.mem_addr) - base + NWORDS) % NWORDS;
        chk("inflight", 32'((issued - popped <= 2) && issued <= blen), 1);
        if (bus.rd_valid && bus.rd_ready) begin
          if (rd_left == 0) chk("rd_extra_word", 1, 0);
          else begin
            chk("rd_data", 32'(bus.rd_data), 32'(exp_rd[0]));
            void'(exp_rd.pop_front());
            rd_left--;
          end
          if (popped == 0) first_pop_cyc = cyc;
          popped++;
          last_pop_cyc = cyc;
          rd_log.push_back(bus.rd_data);
          if (rd_left == 0) done_due = cyc + 1;
        end
      end
      if (active && cyc == done_due) begin
        active = 0; done_cyc = cyc; done_cnt++;
      end else if (!active && bus.cmd_valid) begin
        active = 1; acc_cyc = cyc; done_due = -1;
        base = int'(bus.cmd_addr); blen = int'(bus.cmd_len);
        written = 0; popped = 0;
        wr_log.delete(); rd_log.delete();
        if (blen == 0) begin
          kind = 0; done_due = cyc + 1;
        end else if (bus.cmd_write) begin
          kind = 1; wr_left = blen; exp_wr = plan_q;
        end else begin
          kind = 2; rd_left = blen; exp_rd.delete();
          for (int i = 0; i < blen; i++)
            exp_rd.push_back(ref_mem[(base + i) % NWORDS]);
        end
      end
    end
  end

  task automatic pulse_rst();
    rst = 1'b1;
    plan_q = nodata; feed_gen++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic issue_cmd(input bit w, input int a, input int l,
                           input logic [DW-1:0] d[$]);
    plan_q = w ? d : nodata;
    feed_gen++;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = LW'(l);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (active && n < 1000) begin
      @(posedge clk); n++;
    end
    #1;
    if (active) begin
      chk("done_timeout", 1, 0);
      pulse_rst();
    end
  endtask

  task automatic run_cmd(input bit w, input int a, input int l,
                         input logic [DW-1:0] d[$]);
    issue_cmd(w, a, l, d);
    wait_done();
  endtask

  initial begin
    logic [DW-1:0] d[$];
    logic [DW-1:0] pf[$];
    int n, dc;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // fill the whole memory so every read has a known value
    d.delete();
    for (int i = 0; i < NWORDS; i++) d.push_back(DW'($urandom));
    pf = d;
    run_cmd(1, 0, NWORDS, d);

    // wrapping write burst
    d.delete();
    for (int i = 0; i < 4; i++) d.push_back(DW'(16'hA000 + i));
    run_cmd(1, 'h3E, 4, d);
    chk("w4_size", 32'(wr_log.size()), 4);
    chk("w4_addr0", 32'(wr_log[0]), 'h3E);
    chk("w4_addr1", 32'(wr_log[1]), 'h3F);
    chk("w4_addr2", 32'(wr_log[2]), 'h00);
    chk("w4_addr3", 32'(wr_log[3]), 'h01);
    chk("w4_done_lat", 32'(done_cyc - acc_cyc), 5);

    // read back with no backpressure
    run_cmd(0, 'h3E, 4, nodata);
    chk("r4_first_lat", 32'(first_pop_cyc - acc_cyc), 3);
    chk("r4_span", 32'(last_pop_cyc - first_pop_cyc), 3);
    chk("r4_done_lat", 32'(done_cyc - acc_cyc), 7);
    for (int i = 0; i < 4; i++)
      chk("r4_word", 32'(rd_log[i]), 32'(16'hA000 + i));

    // read under backpressure
    issue_cmd(0, 'h10, 8, nodata);
    rr_mode = 2;
    repeat (8) @(posedge clk);
    #1 rr_mode = 3;
    repeat (5) @(posedge clk);
    #1 rr_mode = 0;
    wait_done();
    chk("bp_count", 32'(rd_log.size()), 8);
    for (int i = 0; i < 8; i++)
      chk("bp_word", 32'(rd_log[i]), 32'(pf[16 + i]));

    // write with two idle cycles between words
    gap_fixed = 2;
    d.delete();
    for (int i = 0; i < 3; i++) d.push_back(DW'(16'hB000 + i));
    run_cmd(1, 5, 3, d);
    gap_fixed = 0;
    chk("gap_count", 32'(wr_log.size()), 3);
    chk("gap_done_lat", 32'(done_cyc - acc_cyc), 8);

    // empty bursts
    run_cmd(1, 9, 0, nodata);
    chk("zw_done_lat", 32'(done_cyc - acc_cyc), 1);
    chk("zw_writes", 32'(wr_log.size()), 0);
    run_cmd(0, 9, 0, nodata);
    chk("zr_done_lat", 32'(done_cyc - acc_cyc), 1);
    chk("zr_reads", 32'(rd_log.size()), 0);

    // reset during the third word of a six-word write
    d.delete();
    for (int i = 0; i < 6; i++) d.push_back(DW'(16'hC000 + i));
    dc = done_cnt;
    issue_cmd(1, 'h20, 6, d);
    n = 0;
    while (wr_log.size() < 2 && n < 50) begin
      @(posedge clk); n++;
    end
    chk("abort_reach", 32'(wr_log.size()), 2);
    #1;
    pulse_rst();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_writes", 32'(wr_log.size()), 2);
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    run_cmd(0, 'h20, 6, nodata);
    chk("abort_rd0", 32'(rd_log[0]), 'hC000);
    chk("abort_rd1", 32'(rd_log[1]), 'hC001);
    chk("abort_rd2", 32'(rd_log[2]), 32'(pf['h22]));
    chk("abort_rd5", 32'(rd_log[5]), 32'(pf['h25]));

    // random bursts
    gap_rand = 1;
    rr_mode  = 1;
    repeat (40) begin
      bit w;
      int a, l;
      w = 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, NWORDS - 1));
      l = int'($urandom_range(0, 12));
      d.delete();
      for (int i = 0; i < l; i++) d.push_back(DW'($urandom));
      run_cmd(w, a, l, d);
    end
    rr_mode = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Burst initiator that drives the single-port synchronous memory port (we/addr/data in, registered out) on behalf of a command-driven client. It accepts a command (write or read, base address, word count), then streams write words from a valid/ready input into consecutive addresses, or streams read words from consecutive addresses to a valid/ready output. A small output buffer absorbs the memory's one-cycle read latency under backpressure. It sits between a controller or DMA-like client and the memory instance, and is that memory's only master.

## Interface
- ADDR_WIDTH, 6, memory address width; addresses wrap modulo 2^ADDR_WIDTH
- DATA_WIDTH, 16, memory word width
- LEN_WIDTH, ADDR_WIDTH+1, width of burst length; max burst 2^LEN_WIDTH-1 words
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  word count; 0 = empty burst
- wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_WIDTH  write-data stream
- rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_WIDTH  read-data stream
- done  out  1  one-cycle pulse at burst completion
- busy  out  1  high in any state other than IDLE
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data  out  DATA_WIDTH  memory write data
- mem_out  in  DATA_WIDTH  memory registered read data

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr into cur_addr and cmd_len into remaining. Go to WRITE or READ by cmd_write. If cmd_len=0, go directly to DONE.
- WRITE:
  - wr_ready=1.
  - mem_we = wr_valid; mem_addr = cur_addr; mem_data = wr_data, combinationally.
  - Each accepted word increments cur_addr (wrapping) and decrements remaining.
  - When the last word is accepted, go to DONE.
- READ:
  - mem_we=0 and mem_addr=cur_addr throughout.
  - Issue a read in a cycle when (fifo_count + pending - pop) < 2, where pop = rd_valid & rd_ready.
  - An issue sets pending for the next cycle, increments cur_addr and decrements remaining.
  - The cycle after an issue, mem_out is written into the 2-entry output FIFO.
  - mem_out is never captured without pending, because the memory updates out on every non-write cycle.
  - After the last issue, go to DRAIN.
- DRAIN: no issues. Once pending=0 and the FIFO is empty, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- rd_valid = (fifo_count != 0); rd_data = FIFO head. rd_valid is never asserted outside READ/DRAIN.
- Write data arriving in IDLE/READ/DRAIN/DONE is not accepted (wr_ready=0).
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, wr_ready=0, rd_valid=0, mem_we=0, FIFO empty, pending=0, cur_addr=0, remaining=0.
- Reset mid-burst: abort with no done pulse and no further memory writes. mem_we is gated by rst so no write occurs in the reset cycle. Buffered read data is discarded.

## Timing
- Write burst of L≥1, cmd accepted at cycle T, wr_valid held high:
  - writes in T+1..T+L
  - done in T+L+1
  - cmd_ready high again in T+L+2
- Read burst of L≥1, cmd accepted at T, rd_ready held high:
  - issues in T+1..T+L
  - rd_valid in T+3..T+L+2, one word per cycle
  - done in T+L+3
- Under backpressure, at most 2 words are buffered plus in flight. No word is lost or duplicated.
- cmd_len=0: done in T+1, no memory access.
- Address wrap: address 2^ADDR_WIDTH-1 is followed by 0.

## Structure
- Package mem_master_pkg: state enum (IDLE, WRITE, READ, DRAIN, DONE) and FIFO depth constant (2).
- Sub-module rd_skid_fifo: 2-entry, DATA_WIDTH-wide FIFO with push/pop/count and synchronous active-high clear, instantiated once for the read path.
- FSM, address/length counters and issue logic live in the top module.

## Test plan
- Write burst: addr=0x3E, len=4, data 0xA000..0xA003 with wr_valid always high -> mem writes to 0x3E, 0x3F, 0x00, 0x01 in consecutive cycles; done 5 cycles after cmd accept.
- Read burst, no backpressure: read back the same 4 words -> rd_data 0xA000..0xA003 on 4 consecutive cycles starting 3 cycles after accept; done at accept+7.
- Read backpressure: len=8, rd_ready toggled 1/0 each cycle, then held low for 5 cycles -> all 8 words delivered in order, no duplicates; issue stalls while FIFO plus pending reaches 2.
- Write gaps: len=3 with wr_valid low for 2 cycles between words -> mem_we asserted only on accepted words; done the cycle after the third word.
- Zero length: cmd_len=0 -> done the cycle after accept, mem_we never asserted, rd_valid never asserted.
- Reset mid-burst: rst asserted during the third word of a len=6 write -> no write in the reset cycle or after; outputs at reset values; no done; next command accepted normally.
